iot_event_arbiter: RTL

IOT_EVENT_ARBITER -- requirements
Module: iot_event_arbiter

---
 rtl/iot_pkg.sv | 10 +
 rtl/iot_rr_arbiter.sv | 28 ++
 rtl/iot_event_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/iot_pkg.sv
// Shared constants and width helper for the IoT event arbiter.
package iot_pkg;
  localparam int   N_DEV_DEFAULT = 4;
  localparam logic DIR_ON        = 1'b1;
  localparam logic DIR_OFF       = 1'b0;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/iot_rr_arbiter.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
module iot_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);
  always_comb begin : arb
    int j;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = $clog2(N)'(j);
      end
    end
  end
endmodule

// File: rtl/iot_event_arbiter.sv
// Per-device on/off event queueing with round-robin issue of one
// registered change strobe per cycle to a downstream active-device counter.
module iot_event_arbiter
  import iot_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DEV-1:0]          dev_req,
  input  logic [N_DEV-1:0]          dev_dir,
  input  logic                      hold,
  input  logic                      clr_drop,
  output logic                      change,
  output logic                      on_off,
  output logic [cnt_w(N_DEV)-1:0]   pending_cnt,
  output logic [N_DEV-1:0]          dropped
);
  localparam int PW = $clog2(N_DEV);
  localparam int CW = cnt_w(N_DEV);

  logic [N_DEV-1:0] pend, pdir, pend_nxt, pdir_nxt, drop_set, grant;
  logic [PW-1:0]    ptr, g_idx;
  logic             any_grant;

  iot_rr_arbiter #(.N(N_DEV)) u_arb (
    .req       (pend),
    .ptr       (ptr),
    .en        (~hold),
    .grant     (grant),
    .grant_idx (g_idx),
    .any_grant (any_grant)
  );

  // A request landing on the granted device is a fresh event, since the
  // grant has already consumed the old one.
  always_comb begin
    pend_nxt = pend & ~grant;
    pdir_nxt = pdir;
    drop_set = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_req[i]) begin
        if (grant[i] || !pend[i]) begin
          pend_nxt[i] = 1'b1;
          pdir_nxt[i] = dev_dir[i];
        end else if (dev_dir[i] != pdir[i]) begin
          pend_nxt[i] = 1'b0;
        end else begin
          drop_set[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < N_DEV; i++) pending_cnt = pending_cnt + CW'(pend[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      pdir    <= '0;
      ptr     <= '0;
      change  <= 1'b0;
      on_off  <= DIR_OFF;
      dropped <= '0;
    end else begin
      pend    <= pend_nxt;
      pdir    <= pdir_nxt;
      dropped <= (clr_drop ? '0 : dropped) | drop_set;
      change  <= any_grant;
      on_off  <= any_grant ? pdir[g_idx] : DIR_OFF;
      if (any_grant)
        ptr <= (int'(g_idx) == N_DEV - 1) ? '0 : g_idx + 1'b1;
    end
  end
endmodule
